// File: rtl/match_window_counter.sv
// match_window_counter
//   Counts single-cycle match pulses (e.g. from a 1101 sequence detector)
//   over a programmable window of window_len clock cycles. It then reports
//   the saturated count and holds it until the consumer acknowledges it.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : asynchronous, active-high
//   in          : match pulse, sampled only while counting
//   enable      : level; high runs windows, low in COUNT aborts the window
//   window_len  : window length in cycles, sampled when a window starts
//   count_ack   : acknowledge of the reported count, honoured only in REPORT
//   count       : matches in the last completed window (saturating)
//   count_valid : count holds an unacknowledged result
//   overflow    : the last reported window saturated
//   busy        : high while in COUNT
module match_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic             count_ack,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [WIN_W-1:0] rem_q, rem_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  // A window can start only with a non-zero length.
  logic start;
  // An increment attempted while already at the maximum is what saturates.
  logic sat_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                               input logic b);
    if (b && (a != CNT_MAX)) return a + CNT_W'(1);
    return a;
  endfunction

  assign start   = enable && (window_len != '0);
  assign sat_hit = in && (acc_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = window_len;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (!enable) begin
          // Abort: drop the partial window, leave the reported result alone.
          acc_d   = '0;
          sat_d   = 1'b0;
          rem_d   = '0;
          state_d = IDLE;
        end else if (rem_q == WIN_W'(1)) begin
          // Last sample of the window is folded straight into the report.
          count_d = sat_inc(acc_q, in);
          ovf_d   = sat_q || sat_hit;
          valid_d = 1'b1;
          acc_d   = '0;
          sat_d   = 1'b0;
          rem_d   = '0;
          state_d = REPORT;
        end else begin
          acc_d = sat_inc(acc_q, in);
          sat_d = sat_q || sat_hit;
          rem_d = rem_q - WIN_W'(1);
        end
      end

      REPORT: begin
        if (count_ack) begin
          valid_d = 1'b0;
          if (start) begin
            rem_d   = window_len;
            acc_d   = '0;
            sat_d   = 1'b0;
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_match_window_counter.sv
module tb_match_window_counter;
  localparam int CNT_W = 3;
  localparam int WIN_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in;
  logic             enable;
  logic [WIN_W-1:0] window_len;
  logic             count_ack;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             overflow;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  match_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .in(in), .enable(enable),
    .window_len(window_len), .count_ack(count_ack), .count(count),
    .count_valid(count_valid), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full window from IDLE: expected result comes from the population
  // count of the sampled bits, clipped to the counter range.
  task automatic do_window(input int len, input logic [31:0] bits,
                           input int ack_delay, output logic [CNT_W-1:0] got);
    int pop;
    logic [CNT_W-1:0] ec;
    logic eo;
    pop = 0;
    for (int i = 0; i < len; i++) pop += int'(bits[i]);
    ec = (pop > MAXC) ? CNT_W'(MAXC) : CNT_W'(pop);
    eo = (pop > MAXC);

    enable = 1'b1; window_len = WIN_W'(len); in = 1'($urandom); count_ack = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b1 || count_valid !== 1'b0) begin
      n_err++;
      $display("FAIL win_start len=%0d: busy=%b valid=%b, required busy=1 valid=0", len, busy, count_valid);
    end
    for (int i = 0; i < len; i++) begin
      in = bits[i];
      window_len = WIN_W'($urandom);
      count_ack = 1'($urandom);
      tick();
      if (i < len - 1) begin
        n_vec++;
        if (busy !== 1'b1 || count_valid !== 1'b0) begin
          n_err++;
          $display("FAIL win_mid len=%0d i=%0d: busy=%b valid=%b, required busy=1 valid=0", len, i, busy, count_valid);
        end
      end
    end
    n_vec++;
    if ({count, count_valid, overflow, busy} !== {ec, 1'b1, eo, 1'b0}) begin
      n_err++;
      $display("FAIL win_report len=%0d: count=%0d valid=%b ovf=%b busy=%b, required count=%0d valid=1 ovf=%b busy=0",
               len, count, count_valid, overflow, busy, ec, eo);
    end
    got = count;
    for (int k = 0; k < ack_delay; k++) begin
      count_ack = 1'b0; in = 1'($urandom); enable = 1'($urandom);
      tick();
      n_vec++;
      if ({count, count_valid, overflow, busy} !== {ec, 1'b1, eo, 1'b0}) begin
        n_err++;
        $display("FAIL win_hold k=%0d: count=%0d valid=%b ovf=%b busy=%b, required count=%0d valid=1 ovf=%b busy=0",
                 k, count, count_valid, overflow, busy, ec, eo);
      end
    end
    enable = 1'b0; count_ack = 1'b1;
    tick();
    n_vec++;
    if ({count, count_valid, overflow, busy} !== {ec, 1'b0, eo, 1'b0}) begin
      n_err++;
      $display("FAIL win_ack: count=%0d valid=%b ovf=%b busy=%b, required count=%0d valid=0 ovf=%b busy=0",
               count, count_valid, overflow, busy, ec, eo);
    end
    count_ack = 1'b0; in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in = 1'b1; enable = 1'b1; window_len = 8'd5; count_ack = 1'b0;
    tick(); tick();
    n_vec++;
    if ({count, count_valid, overflow, busy} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: count=%0d valid=%b ovf=%b busy=%b, required all zero", count, count_valid, overflow, busy);
    end
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; in = 1'b0;
  endtask

  task automatic test_chain();
    logic [6:0] stream;
    logic [2:0] hist;
    logic [31:0] bits;
    logic b;
    logic [CNT_W-1:0] got;
    stream = 7'b1101101;
    hist = 3'b000;
    bits = '0;
    // Overlapping Mealy 1101 detector: output while seeing 1 after 110.
    for (int i = 0; i < 16; i++) begin
      b = (i < 7) ? stream[6 - i] : 1'b0;
      bits[i] = (hist == 3'b110) && b;
      hist = {hist[1:0], b};
    end
    do_window(16, bits, 2, got);
    n_vec++;
    if (got !== 3'd2) begin
      n_err++;
      $display("FAIL chain_1101: count=%0d, required 2", got);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] got;
    do_window(9, 32'h1FF, 0, got);   // 9 ones into 3 bits -> 7, overflow
    do_window(4, 32'h0, 1, got);     // clean window clears overflow
    do_window(7, 32'h7F, 0, got);    // exactly full, no overflow
  endtask

  task automatic test_random();
    logic [CNT_W-1:0] got;
    int len;
    logic [31:0] bits;
    for (int w = 0; w < 15; w++) begin
      len = $urandom_range(1, 12);
      bits = (w % 3 == 0) ? ($urandom | $urandom) : $urandom;
      do_window(len, bits, $urandom_range(0, 3), got);
    end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1; window_len = 8'd3; tick();
    in = 1'b1; tick(); in = 1'b0; tick(); in = 1'b1; tick();
    for (int k = 0; k < 10; k++) begin
      in = 1'($urandom); count_ack = 1'b0; window_len = WIN_W'($urandom);
      tick();
      n_vec++;
      if ({count, count_valid, busy} !== {3'd2, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL b2b_hold k=%0d: count=%0d valid=%b busy=%b, required count=2 valid=1 busy=0", k, count, count_valid, busy);
      end
    end
    count_ack = 1'b1; enable = 1'b1; window_len = 8'd4;
    tick();
    count_ack = 1'b0;
    n_vec++;
    if ({count, count_valid, busy} !== {3'd2, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_restart: count=%0d valid=%b busy=%b, required count=2 valid=0 busy=1", count, count_valid, busy);
    end
    for (int i = 0; i < 4; i++) begin
      in = (i < 3); window_len = WIN_W'($urandom); tick();
    end
    n_vec++;
    if ({count, count_valid, overflow} !== {3'd3, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_second: count=%0d valid=%b ovf=%b, required count=3 valid=1 ovf=0", count, count_valid, overflow);
    end
    enable = 1'b0; count_ack = 1'b1; tick(); count_ack = 1'b0; in = 1'b0;
  endtask

  task automatic test_abort();
    logic [CNT_W-1:0] got;
    do_window(4, 32'h5, 0, got);        // prior result: 2
    enable = 1'b1; window_len = 8'd8; tick();
    in = 1'b1; tick();                   // sample 1
    enable = 1'b0; tick();               // 2nd window edge aborts
    n_vec++;
    if ({count, count_valid, busy} !== {3'd2, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL abort: count=%0d valid=%b busy=%b, required count=2 valid=0 busy=0", count, count_valid, busy);
    end
    tick();
    n_vec++;
    if ({count_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_idle: valid=%b busy=%b, required 0 0", count_valid, busy);
    end
    in = 1'b0;
    do_window(2, 32'h2, 0, got);         // accumulator must start from zero
  endtask

  task automatic test_reset_report();
    logic [CNT_W-1:0] got;
    enable = 1'b1; window_len = 8'd5; tick();
    for (int i = 0; i < 5; i++) begin in = 1'b1; tick(); end
    n_vec++;
    if ({count, count_valid} !== {3'd5, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset: count=%0d valid=%b, required count=5 valid=1", count, count_valid);
    end
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if ({count, count_valid, overflow, busy} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: count=%0d valid=%b ovf=%b busy=%b, required all zero", count, count_valid, overflow, busy);
    end
    #1 reset = 1'b0; enable = 1'b0; in = 1'b0;
    do_window(3, 32'h6, 1, got);
  endtask

  task automatic test_zero_len();
    enable = 1'b1; window_len = 8'd0; count_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in = 1'($urandom); tick();
      n_vec++;
      if ({count_valid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL zero_len k=%0d: valid=%b busy=%b, required 0 0", k, count_valid, busy);
      end
    end
    window_len = 8'd1; count_ack = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in = 1'($urandom); tick();
      n_vec++;
      if (k % 2 == 0) begin
        if ({count_valid, busy} !== 2'b01) begin
          n_err++;
          $display("FAIL len1_count k=%0d: valid=%b busy=%b, required valid=0 busy=1", k, count_valid, busy);
        end
      end else if ({count, count_valid, overflow, busy} !== {2'b00, in, 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL len1_report k=%0d: count=%0d valid=%b ovf=%b busy=%b, required count=%0d valid=1 ovf=0 busy=0",
                 k, count, count_valid, overflow, busy, in);
      end
    end
    enable = 1'b0; tick(); count_ack = 1'b0; in = 1'b0;
    n_vec++;
    if ({count_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL len1_stop: valid=%b busy=%b, required 0 0", count_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_saturation();
    test_back_to_back();
    test_abort();
    test_reset_report();
    test_zero_len();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
